// File: rtl/exe_muldiv_unit.sv
// Iterative multiply/divide engine for the EXE stage: signed/unsigned multiply,
// multiply-accumulate/subtract and restoring divide, all producing a HI/LO pair.
module exe_muldiv_unit #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] hi_i,
   input  logic [WIDTH-1:0] lo_i,
   input  logic             flush_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   CNT_MUL  = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0]   CNT_DIV  = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0]   MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_DIV  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t             state_r, state_s;
   logic               busy_r, done_r;
   logic [WIDTH-1:0]   hi_r, lo_r;
   logic [2:0]         op_r;
   logic [WIDTH-1:0]   a_r, b_r;
   logic [2*WIDTH-1:0] acc_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [WIDTH-1:0]   rem_r, quo_r, dvs_r;
   logic               neg_q_r, neg_r_r;

   logic [2*WIDTH-1:0] ext_a_s, ext_b_s, prod_s, mul_res_s;
   logic [WIDTH:0]     shifted_s, diff_s;
   logic [WIDTH-1:0]   rem_next_s, quo_next_s, fix_hi_s, fix_lo_s;
   logic               signed_op_s;

   // MSUB* shares op[1]=1 with divide, so op[2] also selects the multiply path.
   function automatic logic is_mul(input logic [2:0] op);
      return op[2] | ~op[1];
   endfunction

   function automatic logic [2*WIDTH-1:0] extend(input logic [WIDTH-1:0] v, input logic sgn);
      return sgn ? {{WIDTH{v[WIDTH-1]}}, v} : {ZERO_W, v};
   endfunction

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? (ZERO_W - v) : v;
   endfunction

   assign busy_o = busy_r;
   assign done_o = done_r;
   assign hi_o   = hi_r;
   assign lo_o   = lo_r;

   // Next-state selection; flush overrides every state, including a start in IDLE.
   always_comb begin
      state_s = state_r;
      if (flush_i) begin
         state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_i) begin
                  state_s = is_mul(op_i) ? ST_MUL : ST_DIV;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_MUL: begin
               if (cnt_r == CNT_ZERO) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_MUL;
               end
            end
            ST_DIV: begin
               if (cnt_r == CNT_ZERO) begin
                  state_s = ST_FIX;
               end else begin
                  state_s = ST_DIV;
               end
            end
            ST_FIX:  state_s = ST_DONE;
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
         endcase
      end
   end

   // Multiply datapath: sign-extended operands give the signed product modulo 2^(2W).
   always_comb begin
      ext_a_s   = extend(a_r, ~op_r[0]);
      ext_b_s   = extend(b_r, ~op_r[0]);
      prod_s    = ext_a_s * ext_b_s;
      mul_res_s = prod_s;
      if (op_r[2]) begin
         if (op_r[1]) begin
            mul_res_s = acc_r - prod_s;
         end else begin
            mul_res_s = acc_r + prod_s;
         end
      end else begin
         mul_res_s = prod_s;
      end
   end

   // One restoring division step on magnitudes.
   always_comb begin
      shifted_s  = {rem_r, quo_r[WIDTH-1]};
      diff_s     = shifted_s - {1'b0, dvs_r};
      rem_next_s = shifted_s[WIDTH-1:0];
      quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
      if (diff_s[WIDTH]) begin
         rem_next_s = shifted_s[WIDTH-1:0];
         quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
      end else begin
         rem_next_s = diff_s[WIDTH-1:0];
         quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
      end
   end

   // Sign fix-up and the divide-by-zero / signed-overflow special results.
   always_comb begin
      fix_lo_s = neg_q_r ? (ZERO_W - quo_r) : quo_r;
      fix_hi_s = neg_r_r ? (ZERO_W - rem_r) : rem_r;
      if (b_r == ZERO_W) begin
         fix_lo_s = ONES_W;
         fix_hi_s = a_r;
      end else if (~op_r[0] && (a_r == MIN_NEG) && (b_r == ONES_W)) begin
         fix_lo_s = a_r;
         fix_hi_s = ZERO_W;
      end else begin
         fix_lo_s = neg_q_r ? (ZERO_W - quo_r) : quo_r;
         fix_hi_s = neg_r_r ? (ZERO_W - rem_r) : rem_r;
      end
   end

   assign signed_op_s = ~op_i[0];

   // State register with registered busy/done flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s == ST_MUL) || (state_s == ST_DIV) || (state_s == ST_FIX);
         done_r  <= (state_s == ST_DONE);
      end
   end

   // Operand capture, latency counter and divider iteration registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_r    <= 3'b000;
         a_r     <= ZERO_W;
         b_r     <= ZERO_W;
         acc_r   <= ZERO_2W;
         cnt_r   <= CNT_ZERO;
         rem_r   <= ZERO_W;
         quo_r   <= ZERO_W;
         dvs_r   <= ZERO_W;
         neg_q_r <= 1'b0;
         neg_r_r <= 1'b0;
      end else if (flush_i) begin
         cnt_r <= CNT_ZERO;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_i) begin
                  op_r    <= op_i;
                  a_r     <= a_i;
                  b_r     <= b_i;
                  acc_r   <= {hi_i, lo_i};
                  cnt_r   <= is_mul(op_i) ? CNT_MUL : CNT_DIV;
                  rem_r   <= ZERO_W;
                  quo_r   <= magnitude(a_i, signed_op_s);
                  dvs_r   <= magnitude(b_i, signed_op_s);
                  neg_q_r <= signed_op_s & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                  neg_r_r <= signed_op_s & a_i[WIDTH-1];
               end
            end
            ST_MUL: begin
               if (cnt_r != CNT_ZERO) begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            ST_DIV: begin
               rem_r <= rem_next_s;
               quo_r <= quo_next_s;
               if (cnt_r != CNT_ZERO) begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   // Result registers: written only on the edge that enters DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_r <= ZERO_W;
         lo_r <= ZERO_W;
      end else if (!flush_i && (state_r == ST_MUL) && (cnt_r == CNT_ZERO)) begin
         hi_r <= mul_res_s[2*WIDTH-1:WIDTH];
         lo_r <= mul_res_s[WIDTH-1:0];
      end else if (!flush_i && (state_r == ST_FIX)) begin
         hi_r <= fix_hi_s;
         lo_r <= fix_lo_s;
      end else begin
         hi_r <= hi_r;
         lo_r <= lo_r;
      end
   end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Scoreboard bench for exe_muldiv_unit: directed vectors push expected HI/LO and
// completion cycle; a negedge monitor pops and compares on every done pulse.
module tb_exe_muldiv_unit;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_i = 1'b0;
   logic [2:0]    op_i = 3'b000;
   logic [W-1:0]  a_i = 32'h0, b_i = 32'h0, hi_i = 32'h0, lo_i = 32'h0;
   logic          flush_i = 1'b0;
   logic          busy_o, done_o;
   logic [W-1:0]  hi_o, lo_o;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          due;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   busy_cnt = 0;

   exe_muldiv_unit #(.WIDTH(W), .MUL_LAT(2)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
      .a_i(a_i), .b_i(b_i), .hi_i(hi_i), .lo_i(lo_i), .flush_i(flush_i),
      .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endfunction

   // Monitor: pops one expectation per done pulse.
   always @(negedge clk) begin
      exp_t e;
      if (busy_o) busy_cnt++;
      if (done_o) begin
         check("busy_low_at_done", {63'd0, busy_o}, 64'd0);
         if (sb.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            check({e.name, "_hi"}, {32'd0, hi_o}, {32'd0, e.hi});
            check({e.name, "_lo"}, {32'd0, lo_o}, {32'd0, e.lo});
            check({e.name, "_latency"}, 64'(cyc), 64'(e.due));
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] h, input logic [31:0] l,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input int lat, input string nm, input bit expect_done);
      exp_t e;
      @(negedge clk);
      start_i = 1'b1; op_i = op; a_i = a; b_i = b; hi_i = h; lo_i = l;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      a_i = 32'hDEAD_BEEF; b_i = 32'h0BAD_F00D; hi_i = 32'h5555_5555; lo_i = 32'hAAAA_AAAA;
      if (expect_done) begin
         e.hi = ehi; e.lo = elo; e.due = cyc + lat; e.name = nm;
         sb.push_back(e);
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (sb.size() == 0) break;
      end
      if (sb.size() != 0) begin
         check("completion_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_busy", {63'd0, busy_o}, 64'd0);
      check("rst_done", {63'd0, done_o}, 64'd0);
      check("rst_hi", {32'd0, hi_o}, 64'd0);
      check("rst_lo", {32'd0, lo_o}, 64'd0);
      rst = 1'b0;

      // DIVU with busy-length check and an ignored start while busy
      busy_cnt = 0;
      issue(3'b011, 32'd100, 32'd7, 32'd0, 32'd0, 32'd2, 32'd14, 33, "divu_100_7", 1'b1);
      repeat (5) @(negedge clk);
      start_i = 1'b1; op_i = 3'b001; a_i = 32'd5; b_i = 32'd5;
      @(negedge clk);
      start_i = 1'b0;
      wait_idle();
      check("divu_busy_cycles", 64'(busy_cnt), 64'd33);

      issue(3'b010, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, "div_m7_2", 1'b1);
      wait_idle();
      issue(3'b010, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'd1, 32'hFFFF_FFFD, 33, "div_7_m2", 1'b1);
      wait_idle();
      issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'h8000_0000, 33, "div_ovf", 1'b1);
      wait_idle();
      issue(3'b011, 32'h1234, 32'd0, 32'd0, 32'd0, 32'h1234, 32'hFFFF_FFFF, 33, "divu_by0", 1'b1);
      wait_idle();
      issue(3'b000, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, "mult_m1_2", 1'b1);
      wait_idle();
      issue(3'b001, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'd1, 32'hFFFF_FFFE, 2, "multu", 1'b1);
      wait_idle();
      issue(3'b111, 32'd3, 32'd2, 32'd0, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, "msubu_wrap", 1'b1);
      wait_idle();
      issue(3'b100, 32'hFFFF_FFFD, 32'd4, 32'd1, 32'd0, 32'd0, 32'hFFFF_FFF4, 2, "madd", 1'b1);
      wait_idle();
      issue(3'b110, 32'hFFFF_FFFE, 32'd5, 32'd0, 32'd100, 32'd0, 32'd110, 2, "msub", 1'b1);
      wait_idle();
      issue(3'b101, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 2, "maddu_carry", 1'b1);
      wait_idle();

      // Flush mid-divide: no done, results held at the previous 1/0
      issue(3'b011, 32'd500, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 0, "flushed", 1'b0);
      repeat (9) @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      check("flush_busy", {63'd0, busy_o}, 64'd0);
      check("flush_hi_held", {32'd0, hi_o}, 64'd1);
      check("flush_lo_held", {32'd0, lo_o}, 64'd0);
      repeat (40) @(negedge clk);

      // Start together with flush in IDLE is dropped
      start_i = 1'b1; flush_i = 1'b1; op_i = 3'b011; a_i = 32'd50; b_i = 32'd5;
      @(negedge clk);
      start_i = 1'b0; flush_i = 1'b0;
      check("start_flush_busy", {63'd0, busy_o}, 64'd0);
      repeat (40) @(negedge clk);
      check("start_flush_hi", {32'd0, hi_o}, 64'd1);
      check("start_flush_lo", {32'd0, lo_o}, 64'd0);

      issue(3'b011, 32'd1000, 32'd3, 32'd0, 32'd0, 32'd1, 32'd333, 33, "divu_after_flush", 1'b1);
      wait_idle();

      // Reset mid-divide clears the outputs
      issue(3'b011, 32'd77, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 0, "reset_abort", 1'b0);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_busy", {63'd0, busy_o}, 64'd0);
      check("rst_mid_done", {63'd0, done_o}, 64'd0);
      check("rst_mid_hi", {32'd0, hi_o}, 64'd0);
      check("rst_mid_lo", {32'd0, lo_o}, 64'd0);
      repeat (40) @(negedge clk);

      issue(3'b001, 32'd6, 32'd7, 32'd0, 32'd0, 32'd0, 32'd42, 2, "multu_after_rst", 1'b1);
      wait_idle();
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
